// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory req/ack port plus the valid/ready path to decode.
// The master modport is the fetch unit; the slave side is memory and decoder.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        instr_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_data,
      output instr,
      output pc,
      output pc_plus4,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_data,
      input  instr,
      input  pc,
      input  pc_plus4,
      input  instr_valid,
      output instr_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, req/ack fetch from imem, valid/ready hand-off to decode, redirects.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_INCR  = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   instr_fetch_unit_if.master        bus,
   input  logic                      branch_i,
   input  logic [1:0]                branch_type_i,
   input  logic                      jump_i,
   input  logic                      zero_i,
   input  logic                      neg_i,
   input  logic [31:0]               branch_target_i,
   input  logic [31:0]               jump_target_i
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]               fetch_cnt_o,
   output logic [31:0]               redirect_cnt_o
`endif
);

   localparam logic [31:0] PcIncr = 32'(PC_INCR);

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StDrain,
      StHold
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic        gap_q, gap_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        valid_q, valid_d;

   logic        cond;
   logic        redirect;
   logic [31:0] target;
   logic        req;
   logic        ack;
   logic        transfer;

   always_comb begin
      cond = 1'b0;
      unique case (branch_type_i)
         2'b00: cond = zero_i;
         2'b01: cond = !zero_i && !neg_i;
         2'b10: cond = !neg_i;
         2'b11: cond = !zero_i;
         default: cond = 1'b0;
      endcase
   end

   assign redirect = jump_i | (branch_i & cond);
   assign target   = jump_i ? jump_target_i : branch_target_i;

   // gap_q blanks the request for one cycle after a redirect that collided with an ack.
   assign req      = ((state_q == StReq) && !gap_q) || (state_q == StDrain);
   assign ack      = req & bus.imem_ack;
   assign transfer = valid_q & bus.instr_ready;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      gap_d        = 1'b0;
      instr_d      = instr_q;
      out_pc_d     = out_pc_q;
      valid_d      = valid_q;

      unique case (state_q)
         StIdle: begin
            state_d = StReq;
         end
         StReq: begin
            if (gap_q) begin
               if (redirect) pc_d = target;
            end else if (redirect) begin
               pc_d = target;
               if (ack) begin
                  gap_d = 1'b1;
               end else begin
                  // The old request is still in flight; finish it at its own address.
                  drain_addr_d = pc_q;
                  state_d      = StDrain;
               end
            end else if (ack) begin
               instr_d  = bus.imem_data;
               out_pc_d = pc_q;
               valid_d  = 1'b1;
               pc_d     = pc_q + PcIncr;
               state_d  = StHold;
            end
         end
         StDrain: begin
            if (redirect) pc_d = target;
            if (ack) state_d = StReq;
         end
         StHold: begin
            if (redirect) pc_d = target;
            if (transfer || redirect) begin
               valid_d = 1'b0;
               state_d = StReq;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         gap_q        <= 1'b0;
         instr_q      <= 32'h0;
         out_pc_q     <= RESET_PC;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         gap_q        <= gap_d;
         instr_q      <= instr_d;
         out_pc_q     <= out_pc_d;
         valid_q      <= valid_d;
      end
   end

   assign bus.imem_req    = req;
   assign bus.imem_addr   = (state_q == StDrain) ? drain_addr_q : pc_q;
   assign bus.instr       = instr_q;
   assign bus.pc          = out_pc_q;
   assign bus.pc_plus4    = out_pc_q + PcIncr;
   assign bus.instr_valid = valid_q;

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] redirect_cnt_q, redirect_cnt_d;
   logic        redirect_act;

   assign redirect_act = redirect && (state_q != StIdle);

   always_comb begin
      fetch_cnt_d    = fetch_cnt_q;
      redirect_cnt_d = redirect_cnt_q;
      if (transfer)     fetch_cnt_d    = fetch_cnt_q + 32'd1;
      if (redirect_act) redirect_cnt_d = redirect_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fetch_cnt_q    <= 32'h0;
         redirect_cnt_q <= 32'h0;
      end else begin
         fetch_cnt_q    <= fetch_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign fetch_cnt_o    = fetch_cnt_q;
   assign redirect_cnt_o = redirect_cnt_q;
`else
   // Counters compiled out; fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change and outputs are checked on the falling edge.
module tb_instr_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        branch_i;
   logic [1:0]  branch_type_i;
   logic        jump_i;
   logic        zero_i;
   logic        neg_i;
   logic [31:0] branch_target_i;
   logic [31:0] jump_target_i;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] redirect_cnt;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int xfers       = 0;
   int x0          = 0;

   instr_fetch_unit_if bus ();

   instr_fetch_unit dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .bus             (bus),
      .branch_i        (branch_i),
      .branch_type_i   (branch_type_i),
      .jump_i          (jump_i),
      .zero_i          (zero_i),
      .neg_i           (neg_i),
      .branch_target_i (branch_target_i),
      .jump_target_i   (jump_target_i)
`ifdef IFU_PERF_CNT_EN
      ,
      .fetch_cnt_o     (fetch_cnt),
      .redirect_cnt_o  (redirect_cnt)
`endif
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (bus.instr_valid && bus.instr_ready) xfers++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_i);
   endtask

   initial begin
      rst_i           = 1'b0;
      branch_i        = 1'b0;
      branch_type_i   = 2'b00;
      jump_i          = 1'b0;
      zero_i          = 1'b0;
      neg_i           = 1'b0;
      branch_target_i = 32'h0;
      jump_target_i   = 32'h0;
      bus.imem_ack    = 1'b0;
      bus.imem_data   = 32'h0;
      bus.instr_ready = 1'b0;

      #12;
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr", bus.instr, 32'h0);
      chk("rst_pc", bus.pc, 32'h0);
      chk("rst_pc4", bus.pc_plus4, 32'h4);

      step(); rst_i = 1'b1;

      // Zero-wait fetch at address 0
      step();
      chk("f0_req", 32'(bus.imem_req), 32'd1);
      chk("f0_addr", bus.imem_addr, 32'h0);
      bus.imem_ack = 1'b1; bus.imem_data = 32'h2001_0005;
      step();
      chk("f0_valid", 32'(bus.instr_valid), 32'd1);
      chk("f0_instr", bus.instr, 32'h2001_0005);
      chk("f0_pc", bus.pc, 32'h0);
      chk("f0_pc4", bus.pc_plus4, 32'h4);
      chk("f0_req_low", 32'(bus.imem_req), 32'd0);
      bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
      step();
      chk("f1_req", 32'(bus.imem_req), 32'd1);
      chk("f1_addr", bus.imem_addr, 32'h4);
      chk("f1_valid", 32'(bus.instr_valid), 32'd0);
      bus.instr_ready = 1'b0; x0 = xfers;

      // Slow memory and a stalled decoder
      step(); chk("slow_addr_a", bus.imem_addr, 32'h4);
      step(); chk("slow_addr_b", bus.imem_addr, 32'h4);
      step(); chk("slow_addr_c", bus.imem_addr, 32'h4);
      chk("slow_req_c", 32'(bus.imem_req), 32'd1);
      bus.imem_ack = 1'b1; bus.imem_data = 32'hDEAD_0001;
      step();
      chk("slow_valid", 32'(bus.instr_valid), 32'd1);
      chk("slow_instr", bus.instr, 32'hDEAD_0001);
      chk("slow_pc", bus.pc, 32'h4);
      bus.imem_ack = 1'b0;
      step();
      chk("stall_instr_a", bus.instr, 32'hDEAD_0001);
      chk("stall_valid_a", 32'(bus.instr_valid), 32'd1);
      chk("stall_req_a", 32'(bus.imem_req), 32'd0);
      step();
      chk("stall_instr_b", bus.instr, 32'hDEAD_0001);
      bus.instr_ready = 1'b1;
      step();
      chk("xfer_valid", 32'(bus.instr_valid), 32'd0);
      chk("xfer_addr", bus.imem_addr, 32'h8);
      chk("xfer_count", 32'(xfers - x0), 32'd1);
      bus.instr_ready = 1'b0; bus.imem_ack = 1'b1; bus.imem_data = 32'h3000_0008;

      // Taken bne while holding pc 8
      step();
      chk("h8_pc", bus.pc, 32'h8);
      chk("h8_valid", 32'(bus.instr_valid), 32'd1);
      bus.imem_ack = 1'b0;
      branch_i = 1'b1; branch_type_i = 2'b11; zero_i = 1'b0; branch_target_i = 32'h40;
      step();
      chk("bne_valid", 32'(bus.instr_valid), 32'd0);
      chk("bne_req", 32'(bus.imem_req), 32'd1);
      chk("bne_addr", bus.imem_addr, 32'h40);

      // Jump plus taken beq in REQ without ack: jump wins, old fetch drains
      jump_i = 1'b1; jump_target_i = 32'h100;
      branch_type_i = 2'b00; zero_i = 1'b1; branch_target_i = 32'h200;
      step();
      chk("drain_addr_a", bus.imem_addr, 32'h40);
      chk("drain_req", 32'(bus.imem_req), 32'd1);
      chk("drain_valid_a", 32'(bus.instr_valid), 32'd0);
      jump_i = 1'b0; branch_i = 1'b0; zero_i = 1'b0;
      step();
      chk("drain_addr_b", bus.imem_addr, 32'h40);
      bus.imem_ack = 1'b1; bus.imem_data = 32'hBAD0_BAD0;
      step();
      chk("jmp_valid", 32'(bus.instr_valid), 32'd0);
      chk("jmp_req", 32'(bus.imem_req), 32'd1);
      chk("jmp_addr", bus.imem_addr, 32'h100);

      // bgt with zero set is not taken
      bus.imem_data = 32'h0000_00D5;
      branch_i = 1'b1; branch_type_i = 2'b01; zero_i = 1'b1; neg_i = 1'b0;
      branch_target_i = 32'h300;
      step();
      chk("gt_valid", 32'(bus.instr_valid), 32'd1);
      chk("gt_instr", bus.instr, 32'h0000_00D5);
      chk("gt_pc", bus.pc, 32'h100);
      chk("gt_pc4", bus.pc_plus4, 32'h104);
      branch_i = 1'b0; zero_i = 1'b0; bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
      step();
      chk("seq_addr", bus.imem_addr, 32'h104);
      chk("seq_valid", 32'(bus.instr_valid), 32'd0);

      // bge taken in the same cycle as an ack: data discarded, one-cycle req gap
      bus.instr_ready = 1'b0;
      branch_i = 1'b1; branch_type_i = 2'b10; neg_i = 1'b0; branch_target_i = 32'h80;
      bus.imem_ack = 1'b1; bus.imem_data = 32'hBAD1_BAD1;
      step();
      chk("gap_req", 32'(bus.imem_req), 32'd0);
      chk("gap_valid", 32'(bus.instr_valid), 32'd0);
      branch_i = 1'b0;
      step();
      chk("ge_req", 32'(bus.imem_req), 32'd1);
      chk("ge_addr", bus.imem_addr, 32'h80);
      chk("ge_valid", 32'(bus.instr_valid), 32'd0);

      // Two jumps while draining: latest target wins, then PC wraps
      bus.imem_ack = 1'b0; jump_i = 1'b1; jump_target_i = 32'h500;
      step();
      chk("dr2_addr_a", bus.imem_addr, 32'h80);
      jump_target_i = 32'hFFFF_FFFC;
      step();
      chk("dr2_addr_b", bus.imem_addr, 32'h80);
      chk("dr2_req", 32'(bus.imem_req), 32'd1);
      jump_i = 1'b0; bus.imem_ack = 1'b1; bus.imem_data = 32'hBAD2_BAD2;
      step();
      chk("latest_addr", bus.imem_addr, 32'hFFFF_FFFC);
      chk("latest_valid", 32'(bus.instr_valid), 32'd0);
      bus.imem_data = 32'hE100_0001;
      step();
      chk("wrap_instr", bus.instr, 32'hE100_0001);
      chk("wrap_pc", bus.pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", bus.pc_plus4, 32'h0);
      bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
      step();
      chk("wrap_addr", bus.imem_addr, 32'h0);
      chk("wrap_req", 32'(bus.imem_req), 32'd1);
      bus.instr_ready = 1'b0;

      // Asynchronous reset with a request outstanding
      #2 rst_i = 1'b0;
      #1;
      chk("arst_req", 32'(bus.imem_req), 32'd0);
      chk("arst_valid", 32'(bus.instr_valid), 32'd0);
      chk("arst_instr", bus.instr, 32'h0);
      chk("arst_pc", bus.pc, 32'h0);
      chk("arst_pc4", bus.pc_plus4, 32'h4);
      bus.imem_ack = 1'b1; bus.imem_data = 32'hBAD3_BAD3;
      jump_i = 1'b1; jump_target_i = 32'h999;
      step(); rst_i = 1'b1;
      step();
      chk("rel_req", 32'(bus.imem_req), 32'd1);
      chk("rel_addr", bus.imem_addr, 32'h0);
      chk("rel_valid", 32'(bus.instr_valid), 32'd0);
      jump_i = 1'b0; bus.imem_data = 32'h2001_0005;
      step();
      chk("refetch_valid", 32'(bus.instr_valid), 32'd1);
      chk("refetch_instr", bus.instr, 32'h2001_0005);
      chk("refetch_pc", bus.pc, 32'h0);
      bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
      step();
      chk("refetch_next", bus.imem_addr, 32'h4);
      bus.instr_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
